// File: rtl/ram_sp_ctrl_if.sv
// Client-side request/response channel of the single-port RAM initiator.
// The client drives the master modport and the controller implements the slave modport.
interface ram_sp_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/ram_sp_ctrl.sv
// Initiator for an async-read / sync-write single-port RAM on a shared tri-state bus.
// One request in flight; every strobe and the bus drive enable come straight from flops.
//
// state | meaning
// IDLE  | ready for a request, bus released, strobes low
// WRITE | single cycle with cs/we high and write data on the bus
// READ  | cs/oe high for RD_WAIT cycles, data sampled on the last edge
// RESP  | bus turnaround, response held until the client takes it
module ram_sp_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int RD_WAIT    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ram_sp_ctrl_if.slave          bus,
   output logic [ADDR_WIDTH-1:0] o_mem_address,
   inout  wire  [DATA_WIDTH-1:0] io_mem_data,
   output logic                  o_mem_cs,
   output logic                  o_mem_we,
   output logic                  o_mem_oe
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_mem_address;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_drive_en;
   logic                  r_cs;
   logic                  r_we;
   logic                  r_oe;
   logic [3:0]            r_wait_cnt;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;

   // Drive enable and oe are only ever set in different states, so the bus never sees two drivers.
   assign io_mem_data   = r_drive_en ? r_wdata : {DATA_WIDTH{1'bz}};
   assign o_mem_address = r_mem_address;
   assign o_mem_cs      = r_cs;
   assign o_mem_we      = r_we;
   assign o_mem_oe      = r_oe;

   assign bus.req_ready = (r_state == IDLE);
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_mem_address <= '0;
         r_wdata       <= '0;
         r_drive_en    <= 1'b0;
         r_cs          <= 1'b0;
         r_we          <= 1'b0;
         r_oe          <= 1'b0;
         r_wait_cnt    <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_mem_address <= bus.req_addr;
                  r_wdata       <= bus.req_wdata;
                  r_cs          <= 1'b1;
                  if (bus.req_we) begin
                     r_state    <= WRITE;
                     r_we       <= 1'b1;
                     r_drive_en <= 1'b1;
                  end else begin
                     r_state    <= READ;
                     r_oe       <= 1'b1;
                     r_wait_cnt <= RD_LOAD;
                  end
               end
            end
            WRITE: begin
               r_state    <= IDLE;
               r_cs       <= 1'b0;
               r_we       <= 1'b0;
               r_drive_en <= 1'b0;
            end
            READ: begin
               if (r_wait_cnt == 4'd0) begin
                  r_state     <= RESP;
                  r_rsp_rdata <= io_mem_data;
                  r_rsp_valid <= 1'b1;
                  r_cs        <= 1'b0;
                  r_oe        <= 1'b0;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 4'd1;
               end
            end
            RESP: begin
               if (r_rsp_valid && bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
